// File: rtl/contador_pkg.sv
// Shared constants for the multichannel up/down counter.
// Holds the error FSM encoding and the fault type codes.
package contador_pkg;

    localparam logic [0:0] ACTIVO = 1'b0;
    localparam logic [0:0] ERROR  = 1'b1;

    localparam logic OVF = 1'b0;
    localparam logic UDF = 1'b1;

endpackage

// File: rtl/contador_canal.sv
// One up/down counter channel with wrap or saturate behaviour.
// Flags a fault on the cycle a push hits max or a pop hits zero.
module contador_canal
    import contador_pkg::*;
#(
    parameter int ANCHO    = 6,
    parameter bit MODO_SAT = 1'b0
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    output logic [ANCHO-1:0] cnt,
    output logic             fault,
    output logic             fault_tipo
);

    localparam logic [ANCHO-1:0] MAXV = '1;

    logic [ANCHO-1:0] cnt_q;
    logic [ANCHO-1:0] cnt_d;

    // clear suppresses push/pop, so it also suppresses faults
    always_comb begin
        cnt_d      = cnt_q;
        fault      = 1'b0;
        fault_tipo = OVF;
        if (clear) begin
            cnt_d = '0;
        end else if (push && !pop) begin
            if (cnt_q == MAXV) begin
                fault      = 1'b1;
                fault_tipo = OVF;
                cnt_d      = MODO_SAT ? MAXV : '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop && !push) begin
            if (cnt_q == '0) begin
                fault      = 1'b1;
                fault_tipo = UDF;
                cnt_d      = MODO_SAT ? '0 : MAXV;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/contador_multicanal.sv
// Multichannel occupancy counter with readout port and sticky error FSM.
// Define CONTADOR_TOTAL_EN to add the registered sum output 'total'.
module contador_multicanal
    import contador_pkg::*;
#(
    parameter  int CANALES  = 4,
    parameter  int ANCHO    = 6,
    parameter  bit MODO_SAT = 1'b0,
    localparam int IDX_W    = $clog2(CANALES)
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic [CANALES-1:0] push,
    input  logic [CANALES-1:0] pop,
    input  logic               clear,
    input  logic               req,
    input  logic [IDX_W-1:0]   idx,
    input  logic               clr_err,
    output logic [ANCHO-1:0]   cuenta,
    output logic               valid,
    output logic               error,
    output logic [IDX_W-1:0]   err_canal,
    output logic               err_tipo
`ifdef CONTADOR_TOTAL_EN
    ,
    output logic [ANCHO+IDX_W-1:0] total
`endif
);

    logic [ANCHO-1:0]   cnt_w [CANALES];
    logic [CANALES-1:0] fault_w;
    logic [CANALES-1:0] tipo_w;

    for (genvar g = 0; g < CANALES; g++) begin : g_canal
        contador_canal #(
            .ANCHO    (ANCHO),
            .MODO_SAT (MODO_SAT)
        ) u_canal (
            .clk        (clk),
            .reset_L    (reset_L),
            .push       (push[g]),
            .pop        (pop[g]),
            .clear      (clear),
            .cnt        (cnt_w[g]),
            .fault      (fault_w[g]),
            .fault_tipo (tipo_w[g])
        );
    end

    // Scan high to low so the lowest faulting channel wins
    logic             hit;
    logic [IDX_W-1:0] f_canal;
    logic             f_tipo;

    always_comb begin
        hit     = 1'b0;
        f_canal = '0;
        f_tipo  = OVF;
        for (int i = CANALES - 1; i >= 0; i--) begin
            if (fault_w[i]) begin
                hit     = 1'b1;
                f_canal = IDX_W'(i);
                f_tipo  = tipo_w[i];
            end
        end
    end

    logic [0:0]       estado_q;
    logic [0:0]       estado_d;
    logic [IDX_W-1:0] canal_q;
    logic [IDX_W-1:0] canal_d;
    logic             tipo_q;
    logic             tipo_d;

    always_comb begin
        estado_d = estado_q;
        canal_d  = canal_q;
        tipo_d   = tipo_q;
        unique case (estado_q)
            ACTIVO: begin
                if (hit) begin
                    estado_d = ERROR;
                    canal_d  = f_canal;
                    tipo_d   = f_tipo;
                end
            end
            ERROR: begin
                if (clr_err && hit) begin
                    canal_d = f_canal;
                    tipo_d  = f_tipo;
                end else if (clr_err) begin
                    estado_d = ACTIVO;
                    canal_d  = '0;
                    tipo_d   = OVF;
                end
            end
            default: estado_d = ACTIVO;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            estado_q <= ACTIVO;
            canal_q  <= '0;
            tipo_q   <= OVF;
        end else begin
            estado_q <= estado_d;
            canal_q  <= canal_d;
            tipo_q   <= tipo_d;
        end
    end

    assign error     = (estado_q == ERROR);
    assign err_canal = canal_q;
    assign err_tipo  = tipo_q;

    logic [ANCHO-1:0] lectura;
    logic [ANCHO-1:0] cuenta_q;
    logic [ANCHO-1:0] cuenta_d;
    logic             valid_q;

    always_comb begin
        lectura = '0;
        if ({1'b0, idx} < (IDX_W+1)'(CANALES)) begin
            lectura = cnt_w[idx];
        end
        cuenta_d = req ? lectura : cuenta_q;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cuenta_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            cuenta_q <= cuenta_d;
            valid_q  <= req;
        end
    end

    assign cuenta = cuenta_q;
    assign valid  = valid_q;

`ifdef CONTADOR_TOTAL_EN
    logic [ANCHO+IDX_W-1:0] suma;
    logic [ANCHO+IDX_W-1:0] total_q;

    always_comb begin
        suma = '0;
        for (int i = 0; i < CANALES; i++) begin
            suma = suma + {{IDX_W{1'b0}}, cnt_w[i]};
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            total_q <= '0;
        end else begin
            total_q <= clear ? '0 : suma;
        end
    end

    assign total = total_q;
`endif

endmodule

// File: tb/tb_contador_multicanal.sv
// Bench for contador_multicanal (default wrap mode, four channels).
// Checks outputs against a plain arithmetic model every cycle.
module tb_contador_multicanal;

    localparam int CANALES = 4;
    localparam int MAXV    = 63;

    logic       clk     = 1'b0;
    logic       reset_L = 1'b0;
    logic [3:0] push    = '0;
    logic [3:0] pop     = '0;
    logic       clear   = 1'b0;
    logic       req     = 1'b0;
    logic [1:0] idx     = '0;
    logic       clr_err = 1'b0;
    logic [5:0] cuenta;
    logic       valid;
    logic       error;
    logic [1:0] err_canal;
    logic       err_tipo;
`ifdef CONTADOR_TOTAL_EN
    logic [7:0] total;
`endif

    contador_multicanal dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .req       (req),
        .idx       (idx),
        .clr_err   (clr_err),
        .cuenta    (cuenta),
        .valid     (valid),
        .error     (error),
        .err_canal (err_canal),
        .err_tipo  (err_tipo)
`ifdef CONTADOR_TOTAL_EN
        ,
        .total     (total)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model of the specified behaviour
    int m_cnt [4] = '{0, 0, 0, 0};
    int m_old [4];
    int m_cuenta = 0;
    int m_valid  = 0;
    int m_err    = 0;
    int m_canal  = 0;
    int m_tipo   = 0;
    int m_total  = 0;
    int fch;
    int ftp;

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < CANALES; i++) m_cnt[i] = 0;
            m_cuenta = 0;
            m_valid  = 0;
            m_err    = 0;
            m_canal  = 0;
            m_tipo   = 0;
            m_total  = 0;
        end else begin
            m_old = m_cnt;
            if (req) m_cuenta = (int'(idx) < CANALES) ? m_old[idx] : 0;
            m_valid = int'(req);
            m_total = 0;
            if (!clear)
                for (int i = 0; i < CANALES; i++) m_total += m_old[i];
            fch = -1;
            ftp = 0;
            for (int i = 0; i < CANALES; i++) begin
                if (clear) begin
                    m_cnt[i] = 0;
                end else if (push[i] && !pop[i]) begin
                    if (m_old[i] == MAXV && fch < 0) begin
                        fch = i;
                        ftp = 0;
                    end
                    m_cnt[i] = (m_old[i] + 1) % (MAXV + 1);
                end else if (pop[i] && !push[i]) begin
                    if (m_old[i] == 0 && fch < 0) begin
                        fch = i;
                        ftp = 1;
                    end
                    m_cnt[i] = (m_old[i] + MAXV) % (MAXV + 1);
                end
            end
            if (fch >= 0 && (m_err == 0 || clr_err)) begin
                m_err   = 1;
                m_canal = fch;
                m_tipo  = ftp;
            end else if (m_err == 1 && clr_err) begin
                m_err   = 0;
                m_canal = 0;
                m_tipo  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cuenta", 32'(cuenta), m_cuenta);
            check("valid", 32'(valid), m_valid);
            check("error", 32'(error), m_err);
            check("err_canal", 32'(err_canal), m_canal);
            check("err_tipo", 32'(err_tipo), m_tipo);
`ifdef CONTADOR_TOTAL_EN
            check("total", 32'(total), m_total);
`endif
        end
    end

    task automatic drv(input logic [3:0] p, input logic [3:0] q,
                       input logic cl, input logic r,
                       input logic [1:0] i, input logic ce);
        push    = p;
        pop     = q;
        clear   = cl;
        req     = r;
        idx     = i;
        clr_err = ce;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        chk_en  = 1'b1;
        check("rst_cuenta", 32'(cuenta), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_error", 32'(error), 0);
        check("rst_canal", 32'(err_canal), 0);

        drv(4'b0000, 4'b0000, 0, 0, 0, 0);
        repeat (5) drv(4'b0100, 4'b0000, 0, 0, 0, 0);
        drv(4'b0000, 4'b0000, 0, 1, 0, 0);
        check("rd_ch0", 32'(cuenta), 0);
        check("rd_ch0_v", 32'(valid), 1);
        drv(4'b0000, 4'b0000, 0, 1, 2, 0);
        check("rd_ch2", 32'(cuenta), 5);
        check("rd_ch2_v", 32'(valid), 1);
        drv(4'b0000, 4'b0000, 0, 0, 0, 0);
        check("hold_cuenta", 32'(cuenta), 5);
        check("hold_valid", 32'(valid), 0);

        repeat (63) drv(4'b0010, 4'b0000, 0, 0, 0, 0);
        drv(4'b0000, 4'b0000, 0, 1, 1, 0);
        check("rd_ch1_max", 32'(cuenta), 63);
        drv(4'b0010, 4'b0000, 0, 0, 0, 0);
        check("ovf_error", 32'(error), 1);
        check("ovf_canal", 32'(err_canal), 1);
        check("ovf_tipo", 32'(err_tipo), 0);
        drv(4'b0000, 4'b0000, 0, 1, 1, 0);
        check("ovf_wrap", 32'(cuenta), 0);
        drv(4'b0000, 4'b0000, 0, 0, 0, 1);
        check("clr_error", 32'(error), 0);

        drv(4'b0000, 4'b1001, 0, 0, 0, 0);
        check("udf_error", 32'(error), 1);
        check("udf_canal", 32'(err_canal), 0);
        check("udf_tipo", 32'(err_tipo), 1);
        drv(4'b1000, 4'b0000, 0, 1, 3, 0);
        check("udf_wrap3", 32'(cuenta), 63);
        check("keep_canal", 32'(err_canal), 0);
        check("keep_tipo", 32'(err_tipo), 1);
        drv(4'b0000, 4'b0000, 0, 0, 0, 1);
        check("clr2_error", 32'(error), 0);
        check("clr2_tipo", 32'(err_tipo), 0);
        drv(4'b0000, 4'b0000, 0, 0, 0, 1);
        check("clr_idle", 32'(error), 0);

        drv(4'b0000, 4'b0010, 0, 0, 0, 0);
        check("udf1_canal", 32'(err_canal), 1);
        drv(4'b0000, 4'b1000, 0, 0, 0, 1);
        check("race_error", 32'(error), 1);
        check("race_canal", 32'(err_canal), 3);
        check("race_tipo", 32'(err_tipo), 1);
        drv(4'b0000, 4'b0000, 0, 0, 0, 1);
        check("clr3_error", 32'(error), 0);

        drv(4'b0001, 4'b0000, 1, 0, 0, 0);
        drv(4'b0000, 4'b0000, 0, 1, 0, 0);
        check("clr_ch0", 32'(cuenta), 0);
        check("clr_err_kept", 32'(error), 0);
        drv(4'b0000, 4'b0000, 0, 1, 3, 0);
        check("clr_ch3", 32'(cuenta), 0);
        repeat (10) drv(4'b0001, 4'b0000, 0, 0, 0, 0);
        drv(4'b0001, 4'b0001, 0, 0, 0, 0);
        drv(4'b0000, 4'b0000, 0, 1, 0, 0);
        check("pushpop", 32'(cuenta), 10);

        drv(4'b0000, 4'b0000, 1, 0, 0, 0);
        repeat (63) drv(4'b1111, 4'b0000, 0, 0, 0, 0);
        drv(4'b0000, 4'b0000, 0, 1, 2, 0);
        check("fill_ch2", 32'(cuenta), 63);
`ifdef CONTADOR_TOTAL_EN
        check("total_full", 32'(total), 252);
`endif

        drv(4'b0001, 4'b0000, 0, 0, 0, 0);
        check("pre_rst_err", 32'(error), 1);
        push = '0;
        req  = 1'b1;
        idx  = 2'd1;
        @(posedge clk);
        #2;
        reset_L = 1'b0;
        #1;
        check("arst_cuenta", 32'(cuenta), 0);
        check("arst_valid", 32'(valid), 0);
        check("arst_error", 32'(error), 0);
        check("arst_canal", 32'(err_canal), 0);
`ifdef CONTADOR_TOTAL_EN
        check("arst_total", 32'(total), 0);
`endif
        @(negedge clk);
        reset_L = 1'b1;
        drv(4'b0000, 4'b0000, 0, 1, 1, 0);
        check("post_ch1", 32'(cuenta), 0);
        check("post_valid", 32'(valid), 1);
        drv(4'b0000, 4'b0000, 0, 1, 2, 0);
        check("post_ch2", 32'(cuenta), 0);
        drv(4'b0000, 4'b0000, 0, 0, 0, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/contador_multicanal.md
Name: contador_multicanal

Overview:
- Parametrised successor of the single-channel 6-bit push counter.
- Keeps CANALES independent up/down counters: push increments a channel, pop decrements it.
- Provides a registered request/valid readout port, a sticky overflow/underflow error FSM with first-fault channel capture, and a wrap or saturate mode.
- Sits beside the FIFO/buffer blocks to track per-channel occupancy or event counts.

Parameters:
- CANALES, 4, number of independent channels (≥2).
- ANCHO, 6, counter width in bits per channel.
- MODO_SAT, 0, 0 = wrap on overflow/underflow; 1 = saturate at 2^ANCHO−1 / 0.
- IDX_W, $clog2(CANALES), width of the channel index (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- push  input  CANALES  per-channel increment request.
- pop  input  CANALES  per-channel decrement request.
- clear  input  1  synchronous clear of all counters.
- req  input  1  readout request.
- idx  input  IDX_W  channel selected for readout, sampled with req.
- clr_err  input  1  acknowledge and clear the error state.
- cuenta  output  ANCHO  registered readout value.
- valid  output  1  cuenta is valid this cycle.
- error  output  1  sticky overflow/underflow flag.
- err_canal  output  IDX_W  channel of the first fault.
- err_tipo  output  1  fault type: 0 = overflow, 1 = underflow.

Behaviour:
- Reset (reset_L=0, asynchronous): all counters are 0.
  - cuenta=0, valid=0, error=0, err_canal=0, err_tipo=0; FSM in ACTIVO.
- Per-channel update each edge, evaluated in parallel for all channels:
  - push only: +1.
  - pop only: −1.
  - push and pop together, or neither: no change.
- Overflow (push at 2^ANCHO−1, no pop):
  - MODO_SAT=0: counter wraps to 0.
  - MODO_SAT=1: counter holds at max.
  - In both modes this is a fault event.
- Underflow (pop at 0, no push):
  - MODO_SAT=0: counter wraps to max.
  - MODO_SAT=1: counter holds at 0.
  - Fault event.
- clear=1: all counters become 0 on the edge; this overrides push/pop that cycle. Error state is unaffected.
- Readout:
  - req=1 at edge N gives cuenta = counter[idx] as held before edge N's update, with valid=1 after edge N.
  - Latency is 1 cycle; valid is a one-cycle pulse per req.
  - Back-to-back reqs give back-to-back valid pulses.
  - idx ≥ CANALES returns cuenta=0 with valid=1.
  - When req=0, cuenta holds its last value and valid=0.
- Error FSM, 2 states:
  - ACTIVO → ERROR on any fault event. err_canal takes the lowest-numbered faulting channel that cycle; err_tipo takes that channel's fault type; error=1.
  - In ERROR: counting continues normally. Further faults do not change err_canal/err_tipo.
  - ERROR → ACTIVO on clr_err=1: error, err_canal and err_tipo return to 0.
  - If clr_err and a new fault occur in the same cycle, the fault wins: stay in ERROR and capture the new fault.
  - clr_err in ACTIVO has no effect.
- Reset asserted mid-operation (including mid-readout) immediately forces reset values. The first edge after release is a normal cycle.

Optional Feature:
- Macro: CONTADOR_TOTAL_EN.
- When defined:
  - Adds output total [ANCHO+IDX_W-1:0], a registered sum of all channel counters, updated 1 cycle after the counter changes.
  - total resets to 0 and clears with clear.
  - total never wraps, because its width covers CANALES×max.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package contador_pkg holds:
  - FSM state encoding: ACTIVO=1'b0, ERROR=1'b1.
  - Fault-type constants: OVF=1'b0, UDF=1'b1.
- Sub-module contador_canal (one channel) is generated CANALES times.
  - Inputs: clk, reset_L, push, pop, clear.
  - Outputs: cnt [ANCHO], fault, fault_tipo.
  - Parameters: ANCHO, MODO_SAT.
- The top level holds the readout mux/register, the priority encoder and the error FSM.

Test Plan:
- Reset, then push[2] for 5 cycles, then req idx=2 → next cycle cuenta=5, valid=1; other channels read 0.
- Channel 1 at 63 (ANCHO=6), push[1]:
  - MODO_SAT=0 → cnt=0, error=1, err_canal=1, err_tipo=0.
  - MODO_SAT=1 → cnt holds 63, same error capture.
- Simultaneous underflow on channels 3 and 0 (both at 0, pop) → err_canal=0, err_tipo=1. A later overflow on channel 2 leaves capture unchanged. clr_err → error=0.
- push[0]=pop[0]=1 at count 10 → stays 10. clear together with push[0] → 0.
- Assert reset_L=0 asynchronously mid-cycle after req with counts nonzero → cuenta, valid, error and all counters 0 immediately, before the next clk edge.
- With CONTADOR_TOTAL_EN, channels at 63,63,63,63 → total=252 one cycle after the last update.
